// File: rtl/pipeline_skid_if.sv
// Valid/ready handshake bundle for pipeline_skid: upstream in_* side, downstream out_* side
// and the status outputs. slave is the stage's view, master is the environment's view.
interface pipeline_skid_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       level;
    logic [CNT_W-1:0] xfer_count;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output level,
        output xfer_count
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  level,
        input  xfer_count
    );
endinterface

// File: rtl/pipeline_skid.sv
// Elastic valid/ready stage with a main register and a skid register; in_ready is derived
// from state only, so there is no combinational path from out_ready to in_ready.
module pipeline_skid #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic           clock,
    input logic           reset,
    pipeline_skid_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready, out_valid, in_xfer, out_xfer;

    // Outputs are forced idle while reset is held, even before the first sampling edge.
    assign in_ready  = reset && (state_q != StFull);
    assign out_valid = reset && (state_q != StEmpty);
    assign in_xfer   = bus.in_valid && in_ready;
    assign out_xfer  = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = out_xfer ? count_q + CNT_W'(1) : count_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    main_d  = bus.in_data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (in_xfer && out_xfer) begin
                    main_d = bus.in_data;
                end else if (in_xfer) begin
                    skid_d  = bus.in_data;
                    state_d = StFull;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        bus.level = 2'd0;
        if (reset) begin
            unique case (state_q)
                StBusy:  bus.level = 2'd1;
                StFull:  bus.level = 2'd2;
                default: bus.level = 2'd0;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = reset ? main_q : '0;
    assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_pipeline_skid.sv
// Directed and randomized checks for pipeline_skid; a second instance with CNT_W=4
// exercises counter wrap.
module tb_pipeline_skid;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    pipeline_skid_if #(.WIDTH(4), .CNT_W(8)) bus ();
    pipeline_skid_if #(.WIDTH(4), .CNT_W(4)) bus4 ();

    pipeline_skid #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipeline_skid #(.WIDTH(4), .CNT_W(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h5;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.level !== 2'd0) $display("FAIL reset_level got %0d want 0", bus.level);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_count !== 8'd0) $display("FAIL reset_xfer got %0d want 0", bus.xfer_count);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 4'h0) $display("FAIL reset_out_data got %h want 0", bus.out_data);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL release_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            bus.in_data = 4'(i);
            tick();
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(i) || bus.in_ready !== 1'b1)
                $display("FAIL stream_word got v=%b d=%h r=%b want v=1 d=%h r=1",
                         bus.out_valid, bus.out_data, bus.in_ready, 4'(i));
            else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if (bus.xfer_count !== 8'd15) $display("FAIL stream_count got %0d want 15", bus.xfer_count);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 4'hA;
        tick();
        bus.in_data = 4'hB;
        tick();
        total_cnt++;
        if (bus.level !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 4'hA)
            $display("FAIL bp_full got lvl=%0d r=%b d=%h want lvl=2 r=0 d=a",
                     bus.level, bus.in_ready, bus.out_data);
        else pass_cnt++;
        bus.in_data = 4'hE;
        tick();
        total_cnt++;
        if (bus.level !== 2'd2 || bus.out_data !== 4'hA)
            $display("FAIL bp_hold got lvl=%0d d=%h want lvl=2 d=a", bus.level, bus.out_data);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.level !== 2'd1 || bus.out_data !== 4'hB || bus.out_valid !== 1'b1)
            $display("FAIL bp_second got lvl=%0d d=%h v=%b want lvl=1 d=b v=1",
                     bus.level, bus.out_data, bus.out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.level !== 2'd0 || bus.out_valid !== 1'b0)
            $display("FAIL bp_empty got lvl=%0d v=%b want lvl=0 v=0", bus.level, bus.out_valid);
        else pass_cnt++;
        bus.in_valid = 1'b1;
        bus.in_data = 4'hC;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hC)
            $display("FAIL bp_next got v=%b d=%h want v=1 d=c", bus.out_valid, bus.out_data);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if (bus.xfer_count !== 8'd18) $display("FAIL bp_count got %0d want 18", bus.xfer_count);
        else pass_cnt++;
    endtask

    task automatic test_full_release();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h1;
        tick();
        bus.in_data = 4'h2;
        tick();
        bus.out_ready = 1'b1;
        bus.in_data = 4'h3;
        tick();
        total_cnt++;
        if (bus.level !== 2'd1 || bus.out_data !== 4'h2 || bus.in_ready !== 1'b1)
            $display("FAIL fr_busy got lvl=%0d d=%h r=%b want lvl=1 d=2 r=1",
                     bus.level, bus.out_data, bus.in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.level !== 2'd1 || bus.out_data !== 4'h3)
            $display("FAIL fr_new got lvl=%0d d=%h want lvl=1 d=3", bus.level, bus.out_data);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if (bus.level !== 2'd0 || bus.xfer_count !== 8'd21)
            $display("FAIL fr_end got lvl=%0d cnt=%0d want lvl=0 cnt=21",
                     bus.level, bus.xfer_count);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus4.in_data = 4'(i);
            tick();
        end
        total_cnt++;
        if (bus4.xfer_count !== 4'h0) $display("FAIL wrap_zero got %0d want 0", bus4.xfer_count);
        else pass_cnt++;
        bus4.in_valid = 1'b0;
        tick();
        total_cnt++;
        if (bus4.xfer_count !== 4'h1) $display("FAIL wrap_one got %0d want 1", bus4.xfer_count);
        else pass_cnt++;
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h7;
        tick();
        bus.in_data = 4'h8;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.level !== 2'd2) $display("FAIL rf_setup got lvl=%0d want 2", bus.level);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.level !== 2'd0 || bus.out_data !== 4'h0)
            $display("FAIL rf_cleared got v=%b lvl=%0d d=%h want v=0 lvl=0 d=0",
                     bus.out_valid, bus.level, bus.out_data);
        else pass_cnt++;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                $display("FAIL rf_no_ghost got v=%b r=%b want v=0 r=1",
                         bus.out_valid, bus.in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_q[$];
        logic [3:0] exp_word;
        int         guard;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total_cnt++;
            if (bus.level !== 2'(exp_q.size()))
                $display("FAIL rnd_level got %0d want %0d", bus.level, exp_q.size());
            else pass_cnt++;
            if (bus.out_valid === 1'b1 && $isunknown(bus.out_data)) begin
                total_cnt++;
                $display("FAIL rnd_x got %h want known", bus.out_data);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra got %h want none", bus.out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.out_data !== exp_word)
                        $display("FAIL rnd_order got %h want %h", bus.out_data, exp_word);
                    else pass_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                exp_word = exp_q.pop_front();
                total_cnt++;
                if (bus.out_data !== exp_word)
                    $display("FAIL rnd_drain got %h want %h", bus.out_data, exp_word);
                else pass_cnt++;
            end
            tick();
            guard++;
        end
        total_cnt++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0)
            $display("FAIL rnd_lost got left=%0d v=%b want left=0 v=0",
                     exp_q.size(), bus.out_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_data = '0;
        bus4.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_release();
        test_wrap();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
